// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file types and widths
// Purpose: common widths and the writeback entry record used by the
//          writeback queue and its forwarding matcher.
// Contents: XLEN (data width), AW (register address width), NUM_REGS,
//           wb_entry_t {rd, data}.
package rf_pkg;

  localparam int XLEN     = 32;
  localparam int AW       = 5;
  localparam int NUM_REGS = 32;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_match_youngest.sv
// rtl/wb_match_youngest.sv - youngest-match forwarding lookup over the writeback queue
// Purpose: report whether any valid queue entry targets query_i, and return the
//          data of the youngest such entry (0 when there is no hit).
// Ports:
//   entries_i  in  DEPTH x wb_entry_t  queue storage
//   valid_i    in  DEPTH               per-slot valid bits
//   head_i     in  $clog2(DEPTH)       slot index of the oldest entry
//   query_i    in  AW                  register being looked up (x0 never hits)
//   hit_o      out 1                   a pending entry targets query_i
//   data_o     out XLEN                youngest matching data, else 0
import rf_pkg::*;

module wb_match_youngest #(
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH)
) (
  input  wb_entry_t         entries_i [DEPTH],
  input  logic [DEPTH-1:0]  valid_i,
  input  logic [PW-1:0]     head_i,
  input  logic [AW-1:0]     query_i,
  output logic              hit_o,
  output logic [XLEN-1:0]   data_o
);

  logic [PW-1:0] idx;

  // Walk from oldest (head) to youngest; a later match overwrites an earlier
  // one, so the surviving value is the youngest.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_i + PW'(i);
      if (valid_i[idx] && (entries_i[idx].rd == query_i) && (query_i != '0)) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/regfile_writeback_queue.sv
// rtl/regfile_writeback_queue.sv - in-order writeback FIFO in front of the register file
// Purpose: buffer ALU/load results, drain one per granted cycle onto the regfile
//          write port, and forward not-yet-committed values to decode.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   wb_valid/wb_ready            producer handshake (wb_ready = ~full)
//   wb_reg, wb_data              destination register and result
//   drain_en                     regfile write port granted this cycle
//   rf_regwrite/write_reg/_data  regfile write port, driven from the head entry
//   query_reg1/2, query_hit1/2,  forwarding lookups (youngest match wins)
//   query_data1/2
//   count, empty, full           occupancy
module regfile_writeback_queue import rf_pkg::wb_entry_t; #(
  parameter int DEPTH = 4,
  parameter int XLEN  = rf_pkg::XLEN,
  parameter int AW    = rf_pkg::AW,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_valid,
  output logic            wb_ready,
  input  logic [AW-1:0]   wb_reg,
  input  logic [XLEN-1:0] wb_data,
  input  logic            drain_en,
  output logic            rf_regwrite,
  output logic [AW-1:0]   rf_write_reg,
  output logic [XLEN-1:0] rf_write_data,
  input  logic [AW-1:0]   query_reg1,
  input  logic [AW-1:0]   query_reg2,
  output logic            query_hit1,
  output logic            query_hit2,
  output logic [XLEN-1:0] query_data1,
  output logic [XLEN-1:0] query_data2,
  output logic [CW-1:0]   count,
  output logic            empty,
  output logic            full
);

  wb_entry_t        mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;
  wb_entry_t        head;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign wb_ready = ~full;
  assign count    = count_q;

  // x0 writes complete the handshake but are dropped: they can never be observed.
  assign push = wb_valid & ~full & (wb_reg != '0);
  assign pop  = drain_en & ~empty;

  assign head          = mem_q[rd_ptr_q];
  assign rf_regwrite   = pop;
  assign rf_write_reg  = empty ? '0 : head.rd;
  assign rf_write_data = empty ? '0 : head.data;

  // Push and pop never hit the same slot: that would need full (push blocked)
  // or empty (pop blocked).
  always_comb begin
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
    if (push) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload needs no reset; the valid vector and count qualify it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{rd: wb_reg, data: wb_data};
    end
  end

  wb_match_youngest #(.DEPTH(DEPTH)) u_match1 (
    .entries_i (mem_q),
    .valid_i   (valid_q),
    .head_i    (rd_ptr_q),
    .query_i   (query_reg1),
    .hit_o     (query_hit1),
    .data_o    (query_data1)
  );

  wb_match_youngest #(.DEPTH(DEPTH)) u_match2 (
    .entries_i (mem_q),
    .valid_i   (valid_q),
    .head_i    (rd_ptr_q),
    .query_i   (query_reg2),
    .hit_o     (query_hit2),
    .data_o    (query_data2)
  );

endmodule
